mux_sel_serializer: RTL and testbench
=====================================

MUX_SEL_SERIALIZER -- requirements
Module: mux_sel_serializer

Interface
REQ-001 Parameter: MSB_FIRST, 0, scan order; 0 steps sel 0->7 (LSB first), 1 steps sel 7->0 (MSB first).
REQ-002 Parameter: DIV_W, 4, width of the bit-hold divider input.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: in_data  input  8  parallel word to serialize.
REQ-006 Port: in_valid  input  1  in_data and div are valid.
REQ-007 Port: in_ready  output  1  block can accept a word; combinational, equals (state==IDLE).
REQ-008 Port: div  input  DIV_W  bit-hold length minus one; each bit is held div+1 cycles.
REQ-009 Port: mux_in  output  8  latched word, drives the data input of the downstream 8:1 mux.
REQ-010 Port: sel  output  3  registered select, drives the mux select.
REQ-011 Port: mux_out  input  1  mux output, mux_in[sel].
REQ-012 Port: ser_out  output  1  registered serial bit, sampled from mux_out.
REQ-013 Port: ser_valid  output  1  ser_out carries a payload bit.
REQ-014 Port: done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT and DONE; encoding is free.
REQ-016 Accept: in_valid && in_ready at edge T SHALL latch in_data into mux_in and div into div_q, set sel to the start index (0, or 7 if MSB_FIRST), load hold counter with div, and enter SHIFT.
REQ-017 SHIFT: hold counter SHALL decrement each cycle; at 0 it SHALL reload div_q and step sel by +1 (-1 if MSB_FIRST).
REQ-018 After the 8th bit has been held div_q+1 cycles, state SHALL go to DONE; sel SHALL not wrap past the end index.
REQ-019 DONE SHALL last exactly one cycle, then state SHALL return to IDLE.
REQ-020 ser_out <= mux_out and ser_valid <= (state==SHIFT) every cycle: ser_valid high from T+2 through T+1+8(div+1), i.e. 8(div+1) consecutive cycles.
REQ-021 done <= (state==DONE): single-cycle pulse at T+2+8(div+1); in_ready SHALL be high again in that same cycle.
REQ-022 in_valid while not IDLE SHALL be ignored; no buffering; the word is not consumed.
REQ-023 div and in_data changes after acceptance SHALL have no effect on the word in flight; mux_in SHALL hold stable from T+1 until the next accept.
REQ-024 In IDLE, sel SHALL sit at the start index; ser_out SHALL hold its last value with ser_valid low.
REQ-025 div=0 SHALL give one bit per cycle; div=all-ones SHALL give 2^DIV_W cycles per bit without counter overflow.

Reset
REQ-026 rst high at an edge SHALL force state=IDLE, mux_in=0, sel=start index, ser_out=0, ser_valid=0, done=0, hold counter=0, div_q=0.
REQ-027 rst during SHIFT or DONE SHALL abort the word: no further ser_valid, no done pulse; in_ready high in the cycle after rst deasserts.
REQ-028 rst SHALL take precedence over a simultaneous in_valid; that word SHALL not be accepted.

Verification
REQ-029 MSB_FIRST=0, div=0, in_data=8'b10110110 accepted at T -> sel 0..7 at T+1..T+8; ser_out 0,1,1,0,1,1,0,1 with ser_valid at T+2..T+9; done at T+10.
REQ-030 Same word, div=3 -> each bit held 4 cycles, ser_valid high 32 cycles (T+2..T+33), done at T+34.
REQ-031 MSB_FIRST=1, div=0, in_data=8'b10110110 -> sel 7..0, ser_out 1,0,1,1,0,1,1,0, done at T+10.
REQ-032 in_valid held high with 8'hA5 then 8'h3C, div=0 -> second word accepted in the done cycle (T+10); in_data changes mid-word do not alter ser_out.
REQ-033 rst pulsed while sel=3 -> next cycle all outputs at reset values, no done pulse, in_ready=1 after rst falls; next word serializes correctly.
REQ-034 div=4'hF with 8'hFF -> 128 ser_valid cycles of 1, done at T+130, sel never exceeds 7.

Source files
------------

// File: rtl/mux_sel_serializer_if.sv
// Handshake and mux-side signals between an upstream word source, the serializer and an external 8:1 mux.
// master is the word source / mux side; slave is the serializer.
interface mux_sel_serializer_if #(
  parameter int DIV_W = 4
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] div;
  logic [7:0]       mux_in;
  logic [2:0]       sel;
  logic             mux_out;
  logic             ser_out;
  logic             ser_valid;
  logic             done;

  modport master (
    output in_data, in_valid, div, mux_out,
    input  in_ready, mux_in, sel, ser_out, ser_valid, done
  );

  modport slave (
    input  in_data, in_valid, div, mux_out,
    output in_ready, mux_in, sel, ser_out, ser_valid, done
  );
endinterface

// File: rtl/mux_sel_serializer.sv
// Serializes an 8-bit word by stepping the select of an external 8:1 mux, holding each bit div+1 cycles.
// First payload bit appears 2 cycles after accept; in_ready is low for the whole word, extra in_valid is ignored.
module mux_sel_serializer #(
  parameter bit MSB_FIRST = 1'b0,
  parameter int DIV_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_sel_serializer_if.slave  bus
);

  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       mux_in_q;
  logic [2:0]       sel_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hold_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             done_q;
  logic             in_ready;
  logic             accept;
  logic             last_bit;

  assign accept   = bus.in_valid && in_ready;
  assign last_bit = (sel_q == END_IDX) && (hold_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_in_q    <= '0;
      sel_q       <= START_IDX;
      div_q       <= '0;
      hold_q      <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ser_valid_q <= (state_q == SHIFT);
      done_q      <= (state_q == DONE);
      // Idle leaves ser_out at the last payload bit instead of tracking the parked select.
      if (state_q != IDLE) begin
        ser_out_q <= bus.mux_out;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            mux_in_q <= bus.in_data;
            div_q    <= bus.div;
            hold_q   <= bus.div;
            sel_q    <= START_IDX;
          end
        end
        SHIFT: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (!last_bit) begin
            hold_q <= div_q;
            sel_q  <= MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
          end
        end
        DONE: begin
          sel_q  <= START_IDX;
          hold_q <= '0;
        end
        default: begin
          sel_q <= START_IDX;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mux_in    = mux_in_q;
  assign bus.sel       = sel_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Drives one LSB-first and one MSB-first serializer with identical stimulus and
// compares every cycle against a word-level model of the expected bit stream.
module tb_mux_sel_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [3:0] div;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux_sel_serializer_if #(.DIV_W(4)) b0 ();
  mux_sel_serializer_if #(.DIV_W(4)) b1 ();

  assign b0.in_data  = in_data;
  assign b0.in_valid = in_valid;
  assign b0.div      = div;
  assign b0.mux_out  = b0.mux_in[b0.sel];
  assign b1.in_data  = in_data;
  assign b1.in_valid = in_valid;
  assign b1.div      = div;
  assign b1.mux_out  = b1.mux_in[b1.sel];

  mux_sel_serializer #(.MSB_FIRST(1'b0), .DIV_W(4)) dut_lsb (.clk(clk), .rst(rst), .bus(b0));
  mux_sel_serializer #(.MSB_FIRST(1'b1), .DIV_W(4)) dut_msb (.clk(clk), .rst(rst), .bus(b1));

  // index 0 = LSB-first instance, index 1 = MSB-first instance
  logic [7:0] mux_in_o[2];
  logic [2:0] sel_o[2];
  logic       ser_out_o[2];
  logic       ser_valid_o[2];
  logic       done_o[2];
  logic       in_ready_o[2];

  assign mux_in_o[0]    = b0.mux_in;
  assign mux_in_o[1]    = b1.mux_in;
  assign sel_o[0]       = b0.sel;
  assign sel_o[1]       = b1.sel;
  assign ser_out_o[0]   = b0.ser_out;
  assign ser_out_o[1]   = b1.ser_out;
  assign ser_valid_o[0] = b0.ser_valid;
  assign ser_valid_o[1] = b1.ser_valid;
  assign done_o[0]      = b0.done;
  assign done_o[1]      = b1.done;
  assign in_ready_o[0]  = b0.in_ready;
  assign in_ready_o[1]  = b1.in_ready;

  function automatic logic [2:0] start_idx(input int u);
    return (u == 1) ? 3'd7 : 3'd0;
  endfunction

  // Position i in transmission order maps to a bit of the word according to scan order.
  function automatic logic [2:0] bit_pos(input int u, input int i);
    logic [2:0] p;
    p = 3'(i);
    return (u == 1) ? (3'd7 - p) : p;
  endfunction

  // Presents a word, waits for acceptance and checks every cycle from the accept edge
  // until in_ready returns. Inputs are scrambled while the word is in flight.
  task automatic run_word(input logic [7:0] data, input logic [3:0] d, input bit hold,
                          output int waited);
    int dd;
    int nb;
    int last;
    logic [7:0] wd;
    logic e_vld;
    logic e_done;
    logic e_rdy;
    wd     = data;
    dd     = int'(d) + 1;
    nb     = 8 * dd;
    last   = nb + 1;
    waited = 0;
    in_data  = data;
    div      = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_o[0] && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_o[0]) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready_o[0], waited);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      e_vld  = (k >= 1) && (k <= nb);
      e_done = (k == last);
      e_rdy  = (k == last);
      for (int u = 0; u < 2; u++) begin
        vectors++;
        if (ser_valid_o[u] !== e_vld) begin
          miscompares++;
          $display("FAIL ser_valid u%0d data=%h div=%0d k=%0d: got %b want %b", u, wd, d, k, ser_valid_o[u], e_vld);
        end
        vectors++;
        if (done_o[u] !== e_done) begin
          miscompares++;
          $display("FAIL done u%0d data=%h div=%0d k=%0d: got %b want %b", u, wd, d, k, done_o[u], e_done);
        end
        vectors++;
        if (in_ready_o[u] !== e_rdy) begin
          miscompares++;
          $display("FAIL in_ready u%0d data=%h div=%0d k=%0d: got %b want %b", u, wd, d, k, in_ready_o[u], e_rdy);
        end
        vectors++;
        if (mux_in_o[u] !== wd) begin
          miscompares++;
          $display("FAIL mux_in u%0d k=%0d: got %h want %h", u, k, mux_in_o[u], wd);
        end
        if (e_vld) begin
          vectors++;
          if (ser_out_o[u] !== wd[bit_pos(u, (k - 1) / dd)]) begin
            miscompares++;
            $display("FAIL ser_out u%0d data=%h div=%0d k=%0d: got %b want %b", u, wd, d, k,
                     ser_out_o[u], wd[bit_pos(u, (k - 1) / dd)]);
          end
        end
        if (k < nb) begin
          vectors++;
          if (sel_o[u] !== bit_pos(u, k / dd)) begin
            miscompares++;
            $display("FAIL sel u%0d div=%0d k=%0d: got %0d want %0d", u, d, k, sel_o[u], bit_pos(u, k / dd));
          end
        end
        if (k == last) begin
          vectors++;
          if (sel_o[u] !== start_idx(u)) begin
            miscompares++;
            $display("FAIL sel_idle u%0d: got %0d want %0d", u, sel_o[u], start_idx(u));
          end
        end
      end
      if (k < last) begin
        in_data  = 8'($urandom);
        div      = 4'($urandom);
        in_valid = hold ? 1'b1 : 1'($urandom);
      end else begin
        in_valid = hold;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if (mux_in_o[u] !== 8'h00) begin
        miscompares++;
        $display("FAIL %s mux_in u%0d: got %h want 00", tag, u, mux_in_o[u]);
      end
      vectors++;
      if (sel_o[u] !== start_idx(u)) begin
        miscompares++;
        $display("FAIL %s sel u%0d: got %0d want %0d", tag, u, sel_o[u], start_idx(u));
      end
      vectors++;
      if (ser_out_o[u] !== 1'b0 || ser_valid_o[u] !== 1'b0 || done_o[u] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s outs u%0d: ser_out=%b ser_valid=%b done=%b want 0 0 0", tag, u,
                 ser_out_o[u], ser_valid_o[u], done_o[u]);
      end
      vectors++;
      if (in_ready_o[u] !== 1'b1) begin
        miscompares++;
        $display("FAIL %s in_ready u%0d: got %b want 1", tag, u, in_ready_o[u]);
      end
    end
  endtask

  // Reset held with in_valid high: the word must not be taken.
  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    div      = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("post_reset");
  endtask

  task automatic test_known_words;
    int w;
    run_word(8'b10110110, 4'd0, 1'b0, w);
    run_word(8'b10110110, 4'd3, 1'b0, w);
  endtask

  task automatic test_back_to_back;
    int w;
    run_word(8'hA5, 4'd0, 1'b1, w);
    run_word(8'h3C, 4'd0, 1'b0, w);
    vectors++;
    if (w !== 0) begin
      miscompares++;
      $display("FAIL back_to_back_gap: second word waited %0d cycles, want 0", w);
    end
  endtask

  task automatic test_max_div;
    int w;
    run_word(8'hFF, 4'hF, 1'b0, w);
  endtask

  // Reset in the middle of a word: abort without a done pulse, then accept a fresh word.
  task automatic test_abort;
    int w;
    logic [3:0] d;
    d = 4'($urandom_range(0, 3));
    in_data  = 8'($urandom);
    div      = d;
    in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready_o[0] && w < 300) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3 * (int'(d) + 1)) @(posedge clk);
    #1;
    vectors++;
    if (sel_o[0] !== 3'd3) begin
      miscompares++;
      $display("FAIL abort_sel: got %0d want 3", sel_o[0]);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset_values("abort");
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        vectors++;
        if (ser_valid_o[u] !== 1'b0 || done_o[u] !== 1'b0 || in_ready_o[u] !== 1'b1) begin
          miscompares++;
          $display("FAIL abort_quiet u%0d c=%0d: ser_valid=%b done=%b in_ready=%b want 0 0 1", u, c,
                   ser_valid_o[u], done_o[u], in_ready_o[u]);
        end
      end
    end
    run_word(8'($urandom), 4'($urandom_range(0, 2)), 1'b0, w);
  endtask

  task automatic test_random;
    int w;
    for (int n = 0; n < 20; n++) begin
      run_word(8'($urandom), 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), w);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    run_word(8'($urandom), 4'd1, 1'b0, w);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    div      = 4'd0;
    test_reset();
    test_known_words();
    test_back_to_back();
    test_max_div();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
